// File: rtl/gpio_led_key.sv
// gpio_led_key
//   Memory-mapped GPIO responder on the CPU data bus. Drives the board LEDs
//   and samples the active-low board key through a synchroniser, a debouncer
//   and sticky press/release event flags.
//
//   Register map (word index = bus_addr[4:2]):
//     0 LED      r/w   bits [LED_WIDTH-1:0]
//     1 LED_SET  w1s   reads 0
//     2 LED_CLR  w1c   reads 0
//     3 KEY_STAT ro    bit0 debounced pressed, bit1 raw synchronised pressed
//     4 EVENT    w1c   bit0 press event, bit1 release event (sticky)
//     5..7       unmapped: reads 0, writes ignored, still acknowledged
//
//   Ports:
//     clk        system clock
//     reset      asynchronous, active-high reset
//     bus_valid  access request, held until bus_ready
//     bus_we     1 = write, 0 = read
//     bus_addr   byte offset, [4:2] select the register
//     bus_wdata  write data
//     bus_rdata  read data, non-zero only during the bus_ready cycle of a read
//     bus_ready  one-cycle completion pulse, one cycle after acceptance
//     key        raw board key, active-low, asynchronous
//     led        LED pins (inverted register when LED_ACTIVE_LOW = 1)
//     key_irq    level copy of EVENT bit0
module gpio_led_key #(
  parameter int LED_WIDTH       = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter bit LED_ACTIVE_LOW  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bus_valid,
  input  logic                 bus_we,
  input  logic [4:0]           bus_addr,
  input  logic [31:0]          bus_wdata,
  output logic [31:0]          bus_rdata,
  output logic                 bus_ready,
  input  logic                 key,
  output logic [LED_WIDTH-1:0] led,
  output logic                 key_irq
);

  localparam logic [2:0]  IDX_LED      = 3'd0;
  localparam logic [2:0]  IDX_LED_SET  = 3'd1;
  localparam logic [2:0]  IDX_LED_CLR  = 3'd2;
  localparam logic [2:0]  IDX_KEY_STAT = 3'd3;
  localparam logic [2:0]  IDX_EVENT    = 3'd4;
  localparam logic [15:0] DEB_MAX      = 16'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t               state;
  state_t               state_next;
  logic                 accept;
  logic                 wr_en;
  logic                 rd_en;
  logic [2:0]           reg_idx;
  logic [LED_WIDTH-1:0] led_q;
  logic [1:0]           event_q;
  logic [1:0]           event_clr;
  logic [31:0]          rd_mux;
  logic [31:0]          rdata_q;
  logic                 ks_p0;
  logic                 ks_p1;
  logic                 deb;
  logic [15:0]          cnt;
  logic                 deb_flip;
  logic                 press_set;
  logic                 release_set;
  logic                 unused_bits;

  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:LED_WIDTH]};

  // Bus handshake FSM: accept in IDLE, acknowledge in RESP, then idle again
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus_valid) begin
          accept     = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus_ready = (state == RESP);
  assign reg_idx   = bus_addr[4:2];
  assign wr_en     = accept & bus_we;
  assign rd_en     = accept & ~bus_we;

  // Key stage p0/p1: two-flop synchroniser on the inverted (active-high) key
  // followed by a counter that must see DEBOUNCE_CYCLES consecutive
  // disagreeing samples before the debounced level follows.
  assign deb_flip    = (ks_p1 != deb) && (cnt == DEB_MAX);
  assign press_set   = deb_flip & ks_p1;
  assign release_set = deb_flip & ~ks_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ks_p0 <= 1'b0;
      ks_p1 <= 1'b0;
      deb   <= 1'b0;
      cnt   <= '0;
    end else begin
      ks_p0 <= ~key;
      ks_p1 <= ks_p0;
      if (ks_p1 == deb) begin
        cnt <= '0;
      end else if (deb_flip) begin
        cnt <= '0;
        deb <= ks_p1;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  // Event flags: a debounce edge in the same cycle as a write-1-clear wins.
  assign event_clr = (wr_en && reg_idx == IDX_EVENT) ? bus_wdata[1:0] : 2'b00;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) event_q <= '0;
    else       event_q <= (event_q & ~event_clr) | {release_set, press_set};
  end

  assign key_irq = event_q[0];

  // LED register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= '0;
    end else if (wr_en) begin
      case (reg_idx)
        IDX_LED:     led_q <= bus_wdata[LED_WIDTH-1:0];
        IDX_LED_SET: led_q <= led_q | bus_wdata[LED_WIDTH-1:0];
        IDX_LED_CLR: led_q <= led_q & ~bus_wdata[LED_WIDTH-1:0];
        default:     led_q <= led_q;
      endcase
    end
  end

  assign led = LED_ACTIVE_LOW ? ~led_q : led_q;

  // Read data is sampled at the accept edge and shown only while bus_ready.
  always_comb begin
    rd_mux = '0;
    case (reg_idx)
      IDX_LED:      rd_mux[LED_WIDTH-1:0] = led_q;
      IDX_KEY_STAT: rd_mux[1:0]           = {ks_p1, deb};
      IDX_EVENT:    rd_mux[1:0]           = event_q;
      default:      rd_mux                = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rd_en ? rd_mux : 32'd0;
  end

  assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_led_key.sv
// tb_gpio_led_key
//   Directed bench for gpio_led_key: bus register access, LED pin mapping,
//   key debounce timing, glitch rejection, event set/clear priority and
//   reset in the middle of an access. Inputs change and outputs are sampled
//   on the falling clock edge.
module tb_gpio_led_key;

  logic        clk;
  logic        reset;
  logic        bus_valid;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        key;
  logic [5:0]  led;
  logic        key_irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  gpio_led_key #(
    .LED_WIDTH(6),
    .DEBOUNCE_CYCLES(4),
    .LED_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus_valid(bus_valid),
    .bus_we(bus_we),
    .bus_addr(bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .key(key),
    .led(led),
    .key_irq(key_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One complete access: request at a falling edge, acknowledge checked one
  // cycle after acceptance, then checked to drop in the following cycle.
  task automatic bus_xfer(input logic we, input logic [4:0] addr,
                          input logic [31:0] wd, output logic [31:0] rdo);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = we;
    bus_addr  = addr;
    bus_wdata = wd;
    @(negedge clk);
    chk("ready_pulse", {31'd0, bus_ready}, 32'd1);
    rdo       = bus_rdata;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = 32'd0;
    @(negedge clk);
    chk("ready_drop", {31'd0, bus_ready}, 32'd0);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wd);
    logic [31:0] dummy;
    bus_xfer(1'b1, addr, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] v;
    bus_xfer(1'b0, addr, 32'd0, v);
    chk(tag, v, exp);
  endtask

  initial begin
    reset     = 1'b1;
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = 5'd0;
    bus_wdata = 32'd0;
    key       = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: reset state
    chk("rst_led_pins", {26'd0, led}, 32'h3F);
    chk("rst_ready", {31'd0, bus_ready}, 32'd0);
    chk("rst_irq", {31'd0, key_irq}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    rd_chk("rst_led_reg", 5'h00, 32'd0);

    // 2: LED register, set/clear aliases, upper write bits ignored
    wr(5'h00, 32'hFFFF_FFD5);
    rd_chk("led_write", 5'h00, 32'h15);
    wr(5'h04, 32'hFFFF_FFE2);
    rd_chk("led_set", 5'h00, 32'h37);
    wr(5'h08, 32'hFFFF_FFC1);
    rd_chk("led_clr", 5'h00, 32'h36);
    chk("led_pins", {26'd0, led}, 32'h09);
    rd_chk("led_set_reads0", 5'h04, 32'd0);
    rd_chk("led_clr_reads0", 5'h08, 32'd0);
    wr(5'h03, 32'h0000_0001);
    rd_chk("byte_offset_ignored", 5'h00, 32'h01);

    // 3: clean press, debounce latency, events, W1C
    key = 1'b0;
    repeat (5) @(negedge clk);
    chk("irq_before_latency", {31'd0, key_irq}, 32'd0);
    @(negedge clk);
    chk("irq_at_latency", {31'd0, key_irq}, 32'd1);
    repeat (14) @(negedge clk);
    rd_chk("keystat_pressed", 5'h0C, 32'h3);
    rd_chk("event_press", 5'h10, 32'h1);
    key = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("keystat_released", 5'h0C, 32'h0);
    rd_chk("event_both", 5'h10, 32'h3);
    wr(5'h10, 32'h1);
    rd_chk("event_after_clr", 5'h10, 32'h2);
    chk("irq_after_clr", {31'd0, key_irq}, 32'd0);
    wr(5'h10, 32'h0);
    rd_chk("event_w0_noeffect", 5'h10, 32'h2);
    wr(5'h10, 32'h2);
    rd_chk("event_cleared", 5'h10, 32'h0);

    // 4: glitches of 1 and 2 cycles, then 3 with a mid-glitch raw read
    key = 1'b0;
    @(negedge clk);
    key = 1'b1;
    repeat (10) @(negedge clk);
    key = 1'b0;
    repeat (2) @(negedge clk);
    key = 1'b1;
    repeat (10) @(negedge clk);
    key = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = 5'h0C;
    @(negedge clk);
    key = 1'b1;
    chk("glitch_ready", {31'd0, bus_ready}, 32'd1);
    chk("glitch_raw_seen", bus_rdata, 32'h2);
    bus_valid = 1'b0;
    repeat (10) @(negedge clk);
    rd_chk("glitch_keystat", 5'h0C, 32'h0);
    rd_chk("glitch_event", 5'h10, 32'h0);
    chk("glitch_irq", {31'd0, key_irq}, 32'd0);

    // 5: W1C of press event on the same edge that sets it
    key = 1'b0;
    repeat (5) @(negedge clk);
    chk("race_pre_irq", {31'd0, key_irq}, 32'd0);
    bus_valid = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = 5'h10;
    bus_wdata = 32'h1;
    @(negedge clk);
    chk("race_ready", {31'd0, bus_ready}, 32'd1);
    bus_valid = 1'b0;
    bus_we    = 1'b0;
    bus_wdata = 32'd0;
    rd_chk("race_set_wins", 5'h10, 32'h1);
    chk("race_irq", {31'd0, key_irq}, 32'd1);
    key = 1'b1;
    repeat (10) @(negedge clk);
    rd_chk("race_release", 5'h10, 32'h3);

    // 6: unmapped access, reset mid-access
    rd_chk("unmapped_read", 5'h18, 32'd0);
    wr(5'h1C, 32'h0000_003F);
    rd_chk("unmapped_write", 5'h00, 32'h01);
    wr(5'h00, 32'h2A);
    @(negedge clk);
    bus_valid = 1'b1;
    bus_we    = 1'b0;
    bus_addr  = 5'h00;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, bus_ready}, 32'd0);
    @(negedge clk);
    bus_valid = 1'b0;
    chk("rst_mid_ready_hold", {31'd0, bus_ready}, 32'd0);
    chk("rst_mid_rdata", bus_rdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_after", {31'd0, bus_ready}, 32'd0);
    chk("rst_mid_led_pins", {26'd0, led}, 32'h3F);
    chk("rst_mid_irq", {31'd0, key_irq}, 32'd0);
    rd_chk("rst_mid_led_reg", 5'h00, 32'd0);
    rd_chk("rst_mid_event", 5'h10, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
